// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage and IF/ID register: PC, req/valid fetch handshake,
// one-entry skid for decode stalls, and branch/jump redirect with in-flight discard.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_id,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic [15:0] if_id_imm16
);

    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] target_q;
    logic [31:0] addr_q;
    logic        req_q;
    logic [31:0] skid_instr_q;
    logic [31:0] skid_pc4_q;
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc4_q;

    logic        accept;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_tgt;

    assign accept       = req_q & imem_valid;
    assign pc_plus4     = pc_q + 32'd4;
    assign redirect_tgt = {redirect_pc[31:2], 2'b00};

    assign imem_req     = req_q;
    assign imem_addr    = addr_q;
    assign if_id_valid  = valid_q;
    assign if_id_instr  = instr_q;
    assign if_id_pc4    = pc4_q;
    assign if_id_imm16  = instr_q[15:0];

    // NOTE: every register here is written with <= so all branches see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            target_q     <= RESET_PC;
            addr_q       <= RESET_PC;
            req_q        <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc4_q   <= 32'h0;
            valid_q      <= 1'b0;
            instr_q      <= 32'h0;
            pc4_q        <= 32'h0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (redirect) begin
                        valid_q <= 1'b0;
                        instr_q <= 32'h0;
                        // With nothing outstanding to drain, retarget the request directly.
                        if (accept || !req_q) begin
                            pc_q   <= redirect_tgt;
                            addr_q <= redirect_tgt;
                            req_q  <= 1'b1;
                        end else begin
                            target_q <= redirect_tgt;
                            state_q  <= DISCARD;
                        end
                    end else if (accept) begin
                        pc_q <= pc_plus4;
                        if (stall_id) begin
                            skid_instr_q <= imem_rdata;
                            skid_pc4_q   <= pc_plus4;
                            req_q        <= 1'b0;
                            state_q      <= HOLD;
                        end else begin
                            valid_q <= 1'b1;
                            instr_q <= imem_rdata;
                            pc4_q   <= pc_plus4;
                            addr_q  <= pc_plus4;
                        end
                    end else if (!req_q) begin
                        req_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        valid_q <= 1'b0;
                        instr_q <= 32'h0;
                        pc_q    <= redirect_tgt;
                        addr_q  <= redirect_tgt;
                        req_q   <= 1'b1;
                        state_q <= FETCH;
                    end else if (!stall_id) begin
                        valid_q <= 1'b1;
                        instr_q <= skid_instr_q;
                        pc4_q   <= skid_pc4_q;
                        addr_q  <= pc_q;
                        req_q   <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                DISCARD: begin
                    if (redirect) begin
                        valid_q  <= 1'b0;
                        instr_q  <= 32'h0;
                        target_q <= redirect_tgt;
                    end
                    // The stale response is dropped; the newest redirect target wins.
                    if (accept) begin
                        pc_q    <= redirect ? redirect_tgt : target_q;
                        addr_q  <= redirect ? redirect_tgt : target_q;
                        state_q <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, reset corner cases,
// and randomized traffic against a queue-based fetch-stream reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        stall_id;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        imem_req, if_id_valid;
    logic [31:0] imem_addr, if_id_instr, if_id_pc4;
    logic [15:0] if_id_imm16;

    logic        req2, valid2;
    logic [31:0] addr2, instr2, pc4_2;
    logic [15:0] imm2;

    int total = 0;
    int bad = 0;
    bit hash_mode = 1'b0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .stall_id(stall_id), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc4(if_id_pc4), .if_id_imm16(if_id_imm16)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req2), .imem_addr(addr2),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .stall_id(stall_id), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_id_valid(valid2), .if_id_instr(instr2),
        .if_id_pc4(pc4_2), .if_id_imm16(imm2)
    );

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        valid;
        logic        ovr;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_v;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return hash_mode ? ({a[15:0], a[31:16]} ^ 32'h1234_5678) : a;
    endfunction

    task automatic drive(input logic st, input logic rd, input logic [31:0] rp,
                         input logic vl, input logic ov);
        stall_id    = st;
        redirect    = rd;
        redirect_pc = rp;
        imem_valid  = vl;
        imem_rdata  = ov ? 32'h8C22_0010 : mem_word(imem_addr);
    endtask

    task automatic add(input logic st, input logic rd, input logic [31:0] rp, input logic vl,
                       input logic ov, input logic er, input logic [31:0] ea, input logic ev,
                       input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.stall = st; v.redir = rd; v.rpc = rp; v.valid = vl; v.ovr = ov;
        v.exp_req = er; v.exp_addr = ea; v.exp_v = ev; v.exp_instr = ei; v.exp_pc4 = ep;
        vecs.push_back(v);
    endtask

    // Reference model state: the next useful fetch address, a pending-drop flag for a
    // response that was in flight at a redirect, and a one-deep queue of kept words.
    logic [31:0] npc;
    bit          drop_next;
    logic [31:0] q_instr[$];
    logic [31:0] q_pc4[$];
    logic        e_valid;
    logic [31:0] e_instr, e_pc4;
    int          delivered;

    initial begin
        logic [31:0] wrap_addr[3];
        logic        p_req;
        logic [31:0] p_addr;
        logic        st, vl, rd;
        logic [31:0] rp;

        wrap_addr[0] = 32'hFFFF_FFF8;
        wrap_addr[1] = 32'hFFFF_FFFC;
        wrap_addr[2] = 32'h0000_0000;

        //  stall redir rpc          valid ovr | req addr         v  instr          pc4
        add(0, 0, 32'h0,   1, 0,   1, 32'h0,   0, 32'h0,        32'h0);
        add(0, 0, 32'h0,   1, 0,   1, 32'h4,   1, 32'h0,        32'h4);
        add(0, 0, 32'h0,   1, 0,   1, 32'h8,   1, 32'h4,        32'h8);
        add(0, 0, 32'h0,   1, 0,   1, 32'hC,   1, 32'h8,        32'hC);
        add(1, 0, 32'h0,   1, 1,   0, 32'hC,   1, 32'h8,        32'hC);
        add(1, 0, 32'h0,   1, 0,   0, 32'hC,   1, 32'h8,        32'hC);
        add(1, 0, 32'h0,   1, 0,   0, 32'hC,   1, 32'h8,        32'hC);
        add(0, 0, 32'h0,   1, 0,   1, 32'h10,  1, 32'h8C220010, 32'h10);
        add(0, 0, 32'h0,   1, 0,   1, 32'h14,  1, 32'h10,       32'h14);
        add(0, 0, 32'h0,   0, 0,   1, 32'h14,  1, 32'h10,       32'h14);
        add(0, 1, 32'h40,  0, 0,   1, 32'h14,  0, 32'h0,        32'h14);
        add(0, 0, 32'h0,   1, 0,   1, 32'h40,  0, 32'h0,        32'h14);
        add(0, 0, 32'h0,   0, 0,   1, 32'h40,  0, 32'h0,        32'h14);
        add(0, 0, 32'h0,   1, 0,   1, 32'h44,  1, 32'h40,       32'h44);
        add(0, 1, 32'h81,  1, 0,   1, 32'h80,  0, 32'h0,        32'h44);
        add(0, 0, 32'h0,   1, 0,   1, 32'h84,  1, 32'h80,       32'h84);
        add(1, 0, 32'h0,   1, 0,   0, 32'h84,  1, 32'h80,       32'h84);
        add(1, 1, 32'hC0,  1, 0,   1, 32'hC0,  0, 32'h0,        32'h84);
        add(0, 0, 32'h0,   1, 0,   1, 32'hC4,  1, 32'hC0,       32'hC4);
        add(0, 1, 32'h100, 0, 0,   1, 32'hC4,  0, 32'h0,        32'hC4);
        add(0, 1, 32'h200, 0, 0,   1, 32'hC4,  0, 32'h0,        32'hC4);
        add(0, 0, 32'h0,   1, 0,   1, 32'h200, 0, 32'h0,        32'hC4);
        add(0, 0, 32'h0,   1, 0,   1, 32'h204, 1, 32'h200,      32'h204);
        add(0, 1, 32'h300, 0, 0,   1, 32'h204, 0, 32'h0,        32'h204);

        drive(0, 0, 32'h0, 0, 0);
        #1 rst_n = 1'b0;
        #3;
        check("reset_req", {31'h0, imem_req}, 32'h0);
        check("reset_addr", imem_addr, 32'h0);
        check("reset_valid", {31'h0, if_id_valid}, 32'h0);
        check("reset_instr", if_id_instr, 32'h0);
        check("reset_pc4", if_id_pc4, 32'h0);
        check("reset_addr_wrap", addr2, 32'hFFFF_FFF8);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].valid, vecs[i].ovr);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].exp_req});
            check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_valid", i), {31'h0, if_id_valid}, {31'h0, vecs[i].exp_v});
            check($sformatf("vec%0d_instr", i), if_id_instr, vecs[i].exp_instr);
            check($sformatf("vec%0d_pc4", i), if_id_pc4, vecs[i].exp_pc4);
            check($sformatf("vec%0d_imm16", i), {16'h0, if_id_imm16},
                  {16'h0, vecs[i].exp_instr[15:0]});
            if (i < 3) check($sformatf("wrap%0d_addr", i), addr2, wrap_addr[i]);
            if (i == 2) check("wrap_pc4", pc4_2, 32'h0);
        end

        // Reset asserted while the last vector left the stage in DISCARD.
        #2 rst_n = 1'b0;
        #1;
        check("midreset_req", {31'h0, imem_req}, 32'h0);
        check("midreset_valid", {31'h0, if_id_valid}, 32'h0);
        check("midreset_addr", imem_addr, 32'h0);
        check("midreset_instr", if_id_instr, 32'h0);
        check("midreset_req_wrap", {31'h0, req2}, 32'h0);
        @(negedge clk);
        drive(0, 0, 32'h0, 1, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_req", {31'h0, imem_req}, 32'h1);
        check("post_reset_valid_ignored", {31'h0, if_id_valid}, 32'h0);
        drive(0, 0, 32'h0, 1, 0);
        @(posedge clk);
        #1;
        check("post_reset_first_valid", {31'h0, if_id_valid}, 32'h1);
        check("post_reset_first_pc4", if_id_pc4, 32'h4);

        // Randomized traffic against the fetch-stream model.
        hash_mode = 1'b1;
        drive(0, 0, 32'h0, 0, 0);
        rst_n = 1'b0;
        npc = 32'h0; drop_next = 0; e_valid = 0; e_instr = 32'h0; e_pc4 = 32'h0;
        delivered = 0;
        q_instr.delete(); q_pc4.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            st = ($urandom_range(0, 3) == 0);
            vl = ($urandom_range(0, 2) != 0);
            rd = (c >= 2) && ($urandom_range(0, 11) == 0);
            rp = $urandom & 32'h0000_3FFF;
            drive(st, rd, rp, vl, 0);
            p_req  = imem_req;
            p_addr = imem_addr;
            @(posedge clk);
            #1;
            if (rd) begin
                e_valid   = 0;
                e_instr   = 32'h0;
                q_instr.delete(); q_pc4.delete();
                drop_next = !(p_req && vl) && p_req;
                npc       = rp & 32'hFFFF_FFFC;
            end else if (p_req && vl) begin
                if (drop_next) begin
                    drop_next = 0;
                end else begin
                    check("rnd_fetch_addr", p_addr, npc);
                    npc = npc + 32'd4;
                    if (!st) begin
                        e_valid = 1; e_instr = mem_word(p_addr); e_pc4 = p_addr + 32'd4;
                        delivered++;
                    end else begin
                        check("rnd_skid_free", q_instr.size(), 0);
                        q_instr.push_back(mem_word(p_addr));
                        q_pc4.push_back(p_addr + 32'd4);
                    end
                end
            end else if (!st && q_instr.size() > 0) begin
                e_valid = 1; e_instr = q_instr.pop_front(); e_pc4 = q_pc4.pop_front();
                delivered++;
            end
            if (p_req && !vl) begin
                check("rnd_req_held", {31'h0, imem_req}, 32'h1);
                check("rnd_addr_held", imem_addr, p_addr);
            end
            if (q_instr.size() > 0) check("rnd_req_low_in_hold", {31'h0, imem_req}, 32'h0);
            check("rnd_valid", {31'h0, if_id_valid}, {31'h0, e_valid});
            check("rnd_instr", if_id_instr, e_instr);
            check("rnd_imm16", {16'h0, if_id_imm16}, {16'h0, e_instr[15:0]});
            if (e_valid) check("rnd_pc4", if_id_pc4, e_pc4);
        end
        check("rnd_progress", {31'h0, delivered > 300}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
